// File: rtl/cpu_lsu_pkg.sv
// rtl/cpu_lsu_pkg.sv - funct3 encodings, FSM state type and access decode helpers for cpu_lsu
package cpu_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Exactly one of load/store must be set, and funct3 must name a real RV32I access of that kind.
  function automatic logic op_illegal(input logic load, input logic store, input logic [2:0] funct3);
    if (load == store) begin
      return 1'b1;
    end
    if (load) begin
      return !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    return !(funct3 inside {F3_SB, F3_SH, F3_SW});
  endfunction

  // funct3[1:0] carries the access size for every legal encoding.
  function automatic logic op_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// rtl/cpu_lsu_align.sv - byte-lane steering: store replication, byte enables, load extract and extend
module cpu_lsu_align
  import cpu_lsu_pkg::*;
(
  input  logic        st_is_load,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    if (!st_is_load) begin
      case (st_funct3)
        F3_SB: begin
          st_be    = 4'b0001 << st_addr_lo;
          st_wdata = {4{st_data[7:0]}};
        end
        F3_SH: begin
          st_be    = 4'b0011 << st_addr_lo;
          st_wdata = {2{st_data[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = st_data;
        end
      endcase
    end
  end

  // Shift the addressed byte/half down to bit 0 before extending.
  assign lane = ld_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      F3_LW:   ld_data = ld_rdata;
      F3_LBU:  ld_data = {24'h0, lane[7:0]};
      F3_LHU:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - RV32I load/store unit: one outstanding access, IDLE -> ACCESS -> RESP handshake
module cpu_lsu
  import cpu_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        illegal_q, illegal_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        req_illegal;
  logic        req_misaligned;

  cpu_lsu_align u_align (
    .st_is_load (load),
    .st_funct3  (funct3),
    .st_addr_lo (addr[1:0]),
    .st_data    (store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  assign req_illegal    = op_illegal(load, store, funct3);
  assign req_misaligned = op_misaligned(funct3, addr[1:0]);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    misaligned_d = 1'b0;
    illegal_d    = 1'b0;
    load_data_d  = load_data_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    is_load_d    = is_load_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          is_load_d   = load;
          funct3_d    = funct3;
          addr_lo_d   = addr[1:0];
          // Faults skip the memory entirely and answer straight from RESP.
          if (req_illegal || req_misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            illegal_d    = req_illegal;
            misaligned_d = !req_illegal;
            load_data_d  = 32'h0;
          end else begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d      = ST_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'b0000;
          resp_valid_d = 1'b1;
          load_data_d  = is_load_q ? ld_data : 32'h0;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      is_load_q    <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      is_load_q    <= is_load_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - self-checking bench for cpu_lsu: directed vector table, random model check, reset cases
module tb_cpu_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_lsu dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .load       (load),
    .store      (store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic        acc;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        mis;
    logic        ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int dly, input logic acc, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] ldv,
                              input logic mis, input logic ill);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd; v.delay = dly;
    v.acc = acc; v.be = be; v.wdata = wd; v.ldata = ldv; v.mis = mis; v.ill = ill;
    return v;
  endfunction

  // Reference: derive every expected response from the ISA rules using sizes and offsets.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int size;
    int off;
    logic [31:0] val;
    r = v;
    off = int'(v.addr % 4);
    case (v.f3 % 4)
      0:       size = 1;
      1:       size = 2;
      default: size = 4;
    endcase
    r.ill = (v.ld == v.st) ||
            (v.ld && !(v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5)) ||
            (v.st && !(v.f3 == 0 || v.f3 == 1 || v.f3 == 2));
    r.mis = !r.ill && ((v.addr % size) != 0);
    r.acc = !r.ill && !r.mis;
    r.be = v.ld ? 4'hF : 4'(((1 << size) - 1) << off);
    if (size == 1)      r.wdata = (v.sdata & 32'hFF) * 32'h01010101;
    else if (size == 2) r.wdata = (v.sdata & 32'hFFFF) * 32'h00010001;
    else                r.wdata = v.sdata;
    r.ldata = 32'h0;
    if (r.acc && v.ld) begin
      val = v.rdata >> (8 * off);
      if (size == 1) begin
        val = val & 32'hFF;
        if (v.f3 == 0 && val >= 128) val = val + 32'hFFFFFF00;
      end else if (size == 2) begin
        val = val & 32'hFFFF;
        if (v.f3 == 1 && val >= 32768) val = val + 32'hFFFF0000;
      end
      r.ldata = val;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    int acc_cycles = 0;
    int resp_cyc = 0;
    int resp_cnt = 0;
    logic [31:0] a0 = 0;
    logic [31:0] wd0 = 0;
    logic [3:0] be0 = 0;
    logic we0 = 0;
    logic stable = 1'b1;
    logic [31:0] ld_got = 0;
    logic mis_got = 0;
    logic ill_got = 0;
    logic rsp_mem_bad = 0;
    @(negedge clk);
    check({tag, ".req_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; load = v.ld; store = v.st; funct3 = v.f3;
    addr = v.addr; store_data = v.sdata; mem_ack = 1'b0;
    cyc = 1;
    while (resp_cnt == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      // A busy unit must ignore new requests and their changing operands.
      req_valid = 1'b1; load = 1'($urandom); store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        acc_cycles++;
        if (acc_cycles == 1) begin
          a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_be !== be0 || mem_wdata !== wd0 || mem_we !== we0) begin
          stable = 1'b0;
        end
        if (acc_cycles == v.delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end else begin
        mem_ack = 1'($urandom);
      end
      if (resp_valid) begin
        resp_cnt++; resp_cyc = cyc;
        ld_got = load_data; mis_got = misaligned; ill_got = illegal;
        rsp_mem_bad = mem_req | mem_we | (mem_be != 4'b0);
        req_valid = 1'b0; mem_ack = 1'b0;
      end
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check({tag, ".resp_single_pulse"}, resp_valid, 1'b0);
    check({tag, ".req_ready_after"}, req_ready, 1'b1);
    check({tag, ".latency"}, resp_cyc, v.acc ? 3 + v.delay : 2);
    check({tag, ".access_cycles"}, acc_cycles, v.acc ? v.delay + 1 : 0);
    check({tag, ".load_data"}, ld_got, v.ldata);
    check({tag, ".misaligned"}, mis_got, v.mis);
    check({tag, ".illegal"}, ill_got, v.ill);
    check({tag, ".mem_idle_in_resp"}, rsp_mem_bad, 1'b0);
    if (v.acc) begin
      check({tag, ".mem_addr"}, a0, {v.addr[31:2], 2'b00});
      check({tag, ".mem_be"}, be0, v.be);
      check({tag, ".mem_we"}, we0, v.st);
      check({tag, ".mem_stable"}, stable, 1'b1);
      if (v.st) check({tag, ".mem_wdata"}, wd0, v.wdata);
    end
  endtask

  vec_t tbl[18];
  vec_t rv;
  int   rs_cnt;

  initial begin
    tbl[0]  = mk(0, 1, 3'd0, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 1, 4'b1000, 32'hDDDDDDDD, 32'h0, 0, 0);
    tbl[1]  = mk(1, 0, 3'd0, 32'h2001, 32'h0, 32'h00008000, 0, 1, 4'hF, 32'h0, 32'hFFFFFF80, 0, 0);
    tbl[2]  = mk(1, 0, 3'd4, 32'h2001, 32'h0, 32'h00008000, 0, 1, 4'hF, 32'h0, 32'h00000080, 0, 0);
    tbl[3]  = mk(1, 0, 3'd2, 32'h2002, 32'h0, 32'h12345678, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[4]  = mk(1, 0, 3'd3, 32'h3000, 32'h0, 32'h12345678, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[5]  = mk(0, 1, 3'd1, 32'h0010, 32'h12345678, 32'h0, 4, 1, 4'b0011, 32'h56785678, 32'h0, 0, 0);
    tbl[6]  = mk(1, 1, 3'd0, 32'h4000, 32'h1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[7]  = mk(0, 0, 3'd2, 32'h4000, 32'h1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[8]  = mk(1, 0, 3'd1, 32'h2002, 32'h0, 32'h80011234, 1, 1, 4'hF, 32'h0, 32'hFFFF8001, 0, 0);
    tbl[9]  = mk(1, 0, 3'd5, 32'h2002, 32'h0, 32'h80011234, 0, 1, 4'hF, 32'h0, 32'h00008001, 0, 0);
    tbl[10] = mk(0, 1, 3'd2, 32'h0044, 32'hCAFEBABE, 32'h0, 2, 1, 4'hF, 32'hCAFEBABE, 32'h0, 0, 0);
    tbl[11] = mk(0, 1, 3'd1, 32'h0013, 32'h5555, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[12] = mk(0, 1, 3'd4, 32'h0000, 32'h5555, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[13] = mk(1, 0, 3'd7, 32'h0003, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    tbl[14] = mk(1, 0, 3'd2, 32'h0100, 32'h0, 32'hDEADBEEF, 1, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
    tbl[15] = mk(0, 1, 3'd0, 32'h0002, 32'h000000A5, 32'h0, 0, 1, 4'b0100, 32'hA5A5A5A5, 32'h0, 0, 0);
    tbl[16] = mk(0, 1, 3'd1, 32'h0002, 32'h0000BEEF, 32'h0, 0, 1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 0);
    tbl[17] = mk(1, 0, 3'd0, 32'h0003, 32'h0, 32'h7F000000, 0, 1, 4'hF, 32'h0, 32'h0000007F, 0, 0);

    reset = 1'b0; req_valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0;
    addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset.outputs_zero",
          {31'h0, resp_valid | misaligned | illegal | mem_req | mem_we | (mem_be != 4'b0) |
                  (mem_addr != 32'h0) | (mem_wdata != 32'h0) | (load_data != 32'h0)}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("reset.req_ready_after_release", req_ready, 1'b1);

    for (int i = 0; i < 18; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      rv.ld = (op < 5) || (op == 9 && 1'($urandom));
      rv.st = (op >= 5 && op < 9) || (op == 9 && 1'($urandom));
      rv.f3 = (i % 3 == 0) ? 3'($urandom) : (rv.ld ? 3'($urandom_range(0, 2)) | {1'b0, 2'b00} : 3'($urandom_range(0, 2)));
      if (rv.ld && (i % 4 == 1)) rv.f3 = 3'($urandom_range(4, 5));
      rv.addr = $urandom; rv.sdata = $urandom; rv.rdata = $urandom;
      rv.delay = int'($urandom_range(0, 3));
      rv = model(rv);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Reset while an access is waiting on its ack.
    @(negedge clk);
    req_valid = 1'b1; load = 1'b0; store = 1'b1; funct3 = 3'd1;
    addr = 32'h0000_0010; store_data = 32'h0000_1234; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("midreset.mem_req_before", mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset.mem_req_dropped", mem_req, 1'b0);
    check("midreset.be_dropped", mem_be, 4'b0);
    @(negedge clk);
    reset = 1'b1;
    rs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      if (resp_valid || mem_req) rs_cnt++;
    end
    mem_ack = 1'b0;
    check("midreset.no_resp_or_req", rs_cnt, 0);
    check("midreset.req_ready", req_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_lsu.md
CPU_LSU -- requirements
Module: cpu_lsu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk  in  1  clock, rising edge
  reset  in  1  async active-low reset
  req_valid  in  1  CPU access request
  req_ready  out  1  high only in IDLE
  load  in  1  load access
  store  in  1  store access
  funct3  in  3  RV32I size/sign field
  addr  in  32  byte address
  store_data  in  32  raw rs2 value
  resp_valid  out  1  one-cycle completion pulse
  load_data  out  32  extended load result
  misaligned  out  1  alignment fault, valid with resp_valid
  illegal  out  1  bad funct3 or op, valid with resp_valid
  mem_req  out  1  memory request
  mem_we  out  1  write enable
  mem_addr  out  32  word address {addr[31:2],2'b00}
  mem_be  out  4  byte enables
  mem_wdata  out  32  lane-replicated write data
  mem_ack  in  1  memory completion
  mem_rdata  in  32  read word, valid with mem_ack

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-004 In IDLE with req_valid=1, the block SHALL capture load, store, funct3, addr and store_data, then go to ACCESS (legal, aligned) or RESP (fault).
REQ-005 In ACCESS, mem_req SHALL be held at 1 with stable mem_we, mem_addr, mem_be and mem_wdata until the cycle mem_ack=1, then go to RESP.
REQ-006 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-007 Minimum latency SHALL be 3 cycles from request to resp_valid (accept, ACCESS with mem_ack in its first cycle, RESP). A fault SHALL give resp_valid 2 cycles after the request.
REQ-008 Legal loads SHALL be funct3 000/001/010/100/101. Legal stores SHALL be 000/001/010.
REQ-009 illegal SHALL be 1 for any other funct3, for load=store=1, or for load=store=0. No memory access SHALL occur.
REQ-010 misaligned SHALL be 1 for halfword with addr[0]=1 or word with addr[1:0]!=0. No memory access SHALL occur. illegal SHALL take priority over misaligned.
REQ-011 Store byte (SB) SHALL drive mem_wdata={4{store_data[7:0]}} and mem_be=4'b0001<<addr[1:0].
REQ-012 Store half (SH) SHALL drive mem_wdata={2{store_data[15:0]}} and mem_be=4'b0011<<addr[1:0].
REQ-013 Store word (SW) SHALL drive mem_wdata=store_data and mem_be=4'b1111.
REQ-014 Loads SHALL drive mem_we=0, mem_be=4'b1111.
REQ-015 Load data SHALL be the byte or half selected by addr[1:0] of mem_rdata, registered on mem_ack. LB and LH SHALL sign-extend from bit 7 or bit 15 of the selected data. LBU and LHU SHALL zero-extend.
REQ-016 load_data SHALL be 0 for stores and faults. It SHALL hold its value outside RESP.
REQ-017 mem_ack outside ACCESS SHALL be ignored. req_valid outside IDLE SHALL be ignored, because req_ready=0.
REQ-018 mem_req, mem_we and mem_be SHALL be 0 in IDLE and RESP.

Reset
REQ-019 When reset=0, the block SHALL asynchronously force IDLE and drive every output to 0 except req_ready. req_ready SHALL be 1 after reset deasserts.
REQ-020 Reset during ACCESS SHALL abandon the memory transaction. No resp_valid SHALL follow.

Structure
REQ-021 Package cpu_lsu_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state encoding.
REQ-022 Sub-module cpu_lsu_align SHALL be the combinational lane and extension logic (store replication, mem_be, load extract/extend). The FSM SHALL stay in cpu_lsu.

Verification
REQ-023 SB with addr=0x1003 and store_data=0xAABBCCDD SHALL give mem_addr=0x1000, mem_be=1000, mem_wdata=0xDDDDDDDD.
REQ-024 LB with addr=0x2001, mem_rdata=0x0000_80_00 and ack in the first ACCESS cycle SHALL give load_data=0xFFFFFF80 on cycle 3. LBU on the same data SHALL give 0x00000080.
REQ-025 LW with addr=0x2002 SHALL give no mem_req and resp_valid with misaligned=1, load_data=0.
REQ-026 A load with funct3=011 SHALL give illegal=1 and no mem_req.
REQ-027 SH with addr=0x10 and ack delayed 4 cycles SHALL hold mem_req and all memory outputs stable. resp_valid SHALL pulse once.
REQ-028 reset=0 mid-ACCESS with ack pending SHALL drop mem_req immediately and give no resp_valid. After release, req_ready SHALL be 1.
